// File: rtl/mat_stream_loader_pkg.sv
// mat_stream_loader_pkg
//   Shared linear-algebra definitions for the matrix stream loader:
//   - FP32_SIGN_BIT : bit index of the sign in an IEEE-754 single
//   - loader_state_t: loader FSM states (FILL collecting beats, FULL holding
//                     a complete matrix for the consumer)
package mat_stream_loader_pkg;

   localparam int FP32_SIGN_BIT = 31;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } loader_state_t;

endpackage

// File: rtl/mat_stream_loader_if.sv
// mat_stream_loader_if
//   Element stream in, whole matrix out.
//   Handshake rule (both sides): a transfer happens on a rising clk edge
//   where valid && ready are both high; valid/data are held by the source
//   until that edge, and ready never depends combinationally on valid.
//   Signals:
//     in_data/in_neg/in_valid : producer -> loader, one element per beat
//     in_ready                : loader -> producer
//     out_mat/out_valid       : loader -> consumer, packed [M][N][W]
//     out_ready               : consumer -> loader
//     count                   : elements accepted into the current matrix
//   Modports: slave = loader side, master = producer/consumer side.
interface mat_stream_loader_if #(
   parameter int M = 2,
   parameter int N = 3,
   parameter int W = mat_stream_loader_pkg::FP32_SIGN_BIT + 1
);
   localparam int CNTW = $clog2(M*N+1);

   logic [W-1:0]                 in_data;
   logic                         in_neg;
   logic                         in_valid;
   logic                         in_ready;
   logic [M-1:0][N-1:0][W-1:0]   out_mat;
   logic                         out_valid;
   logic                         out_ready;
   logic [CNTW-1:0]              count;

   modport slave (
      input  in_data, in_neg, in_valid, out_ready,
      output in_ready, out_mat, out_valid, count
   );

   modport master (
      output in_data, in_neg, in_valid, out_ready,
      input  in_ready, out_mat, out_valid, count
   );

endinterface

// File: rtl/mat_index_counter.sv
// mat_index_counter
//   Row/column position of the next element in a row-major M x N fill.
//   Ports:
//     clk, rst : clock, synchronous active-high reset
//     clr      : restart at element 0 (matrix handed off)
//     inc      : one element accepted this cycle
//     row, col : target position of the next element
//     idx      : elements accepted so far (0..M*N)
//     last     : the next element completes the matrix
//   After the last element idx parks at M*N and row/col return to 0 so the
//   next fill starts cleanly once clr arrives.
module mat_index_counter #(
   parameter int M = 2,
   parameter int N = 3
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              clr,
   input  logic                              inc,
   output logic [((M > 1) ? $clog2(M) : 1)-1:0] row,
   output logic [((N > 1) ? $clog2(N) : 1)-1:0] col,
   output logic [$clog2(M*N+1)-1:0]          idx,
   output logic                              last
);
   localparam int RW   = (M > 1) ? $clog2(M) : 1;
   localparam int CW   = (N > 1) ? $clog2(N) : 1;
   localparam int CNTW = $clog2(M*N+1);

   assign last = (idx == CNTW'(M*N-1));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         row <= '0;
         col <= '0;
         idx <= '0;
      end else if (inc) begin
         idx <= idx + 1'b1;
         if (last) begin
            row <= '0;
            col <= '0;
         end else if (col == CW'(N-1)) begin
            col <= '0;
            row <= row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // RW is only used to size the row port; keep it referenced for clarity.
   logic unused_rw;
   assign unused_rw = (RW > 0);

endmodule

// File: rtl/mat_stream_loader.sv
// mat_stream_loader
//   Collects M*N elements, row-major, into a packed flop matrix and offers
//   it to a consumer. An element may be negated on entry by flipping its
//   sign bit (no NaN/zero special cases, so +0 becomes -0).
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     bus       : mat_stream_loader_if.slave (element in, matrix out, count)
//     fsm_state : current FSM state, for observation
//   FILL accepts one element per cycle; the last one moves to FULL, where
//   inputs stall and the matrix is held until out_ready. Contents stay in
//   place after hand-off until overwritten by the next fill.
module mat_stream_loader
   import mat_stream_loader_pkg::*;
#(
   parameter int M = 2,
   parameter int N = 3,
   parameter int W = FP32_SIGN_BIT + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   mat_stream_loader_if.slave   bus,
   output loader_state_t        fsm_state
);
   localparam int RW   = (M > 1) ? $clog2(M) : 1;
   localparam int CW   = (N > 1) ? $clog2(N) : 1;
   localparam int CNTW = $clog2(M*N+1);

   loader_state_t               state;
   logic                        in_ready_q;
   logic                        out_valid_q;
   logic [M-1:0][N-1:0][W-1:0]  mat_q;

   logic [RW-1:0]   row;
   logic [CW-1:0]   col;
   logic [CNTW-1:0] idx;
   logic            last;
   logic            accept;
   logic            handoff;
   logic [W-1:0]    elem;

   // in_ready_q is high exactly in FILL, so it doubles as the state gate.
   assign accept  = in_ready_q && bus.in_valid;
   assign handoff = out_valid_q && bus.out_ready;

   always_comb begin
      elem        = bus.in_data;
      elem[W-1]   = bus.in_data[W-1] ^ bus.in_neg;
   end

   mat_index_counter #(.M(M), .N(N)) u_index (
      .clk  (clk),
      .rst  (rst),
      .clr  (handoff),
      .inc  (accept),
      .row  (row),
      .col  (col),
      .idx  (idx),
      .last (last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FILL;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         mat_q       <= '0;
      end else begin
         case (state)
            FILL: begin
               if (accept) begin
                  mat_q[row][col] <= elem;
                  if (last) begin
                     state       <= FULL;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                  end
               end
            end
            FULL: begin
               if (handoff) begin
                  state       <= FILL;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state       <= FILL;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_mat   = mat_q;
   assign bus.count     = idx;
   assign fsm_state     = state;

endmodule

// File: doc/mat_stream_loader.md
MAT_STREAM_LOADER -- requirements
Module: mat_stream_loader

Interface
REQ-001 Parameter M, default 2, number of matrix rows.
REQ-002 Parameter N, default 3, number of matrix columns.
REQ-003 Parameter W, default 32, element width; elements are IEEE-754 single bit patterns.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_data  input  W  one matrix element per beat, row-major order.
REQ-007 in_neg  input  1  when high on an accepted beat, that element is stored with bit W-1 inverted.
REQ-008 in_valid  input  1  producer has a valid element.
REQ-009 in_ready  output  1  loader accepts an element this cycle.
REQ-010 out_mat  output  [M-1:0][N-1:0][W-1:0]  assembled matrix, packed.
REQ-011 out_valid  output  1  out_mat holds a complete matrix.
REQ-012 out_ready  input  1  consumer takes out_mat.
REQ-013 count  output  $clog2(M*N+1)  number of elements accepted into the current matrix.

Function
REQ-014 Beat accepted iff in_valid && in_ready at a rising edge.
REQ-015 k-th accepted beat, k = 0..M*N-1, writes out_mat[k/N][k%N]; no other element changes on that edge.
REQ-016 Stored value: in_data with bit W-1 XOR in_neg; all other bits pass unmodified. No NaN/zero special-casing: -0 is produced from +0.
REQ-017 FSM states: FILL, FULL.
REQ-018 FILL: in_ready=1, out_valid=0; accepted beat increments count; the beat with count==M*N-1 moves to FULL with count=M*N.
REQ-019 FULL: in_ready=0, out_valid=1, out_mat and count frozen.
REQ-020 FULL with out_ready=1 moves to FILL with count=0; out_mat contents are retained until overwritten.
REQ-021 Latency: out_valid rises the cycle after the last beat is accepted; in_ready rises the cycle after the out handshake; maximum throughput is one matrix per M*N+1 cycles.
REQ-022 in_valid while in FULL: no state change, and the data is not consumed.
REQ-023 out_ready while in FILL: ignored.
REQ-024 Degenerate M*N==1: every accepted beat goes directly to FULL.

Reset
REQ-025 rst high at any edge forces FILL, count=0, out_valid=0, in_ready=1 on the following cycle, and clears out_mat to all zeros.
REQ-026 Reset mid-fill or while FULL discards the partial or pending matrix; no handshake completes on the reset edge.

Structure
REQ-027 Shared linalg package holds the FP32 sign-bit index constant and the state enum type (FILL, FULL).
REQ-028 Row and column indices are tracked by one counter sub-module, mat_index_counter (row, col, and wrap at M×N); the loader instantiates it once.
REQ-029 Storage is a flop array; no RAM inference is required.

Verification
REQ-030 M=2, N=3, in_neg=0: stream 3F800000, 40000000, 40400000, 40800000, 40A00000, 40C00000 -> out_mat[0]={3F800000, 40000000, 40400000}, out_mat[1]={40800000, 40A00000, 40C00000}, and out_valid rises one cycle after the 6th beat.
REQ-031 Same stream with in_neg=1 on all beats -> elements BF800000, C0000000, C0400000, C0800000, C0A00000, C0C00000; in_neg=1 with 00000000 -> 80000000.
REQ-032 In FULL, hold out_ready=0 for 5 cycles while driving in_valid=1 with data 41000000 -> out_mat unchanged, in_ready=0, count=6; then out_ready=1 -> FILL on the next cycle.
REQ-033 Random in_valid gaps (about 50%) over 3 back-to-back matrices -> each matrix matches the row-major reference model, with no dropped or duplicated beats.
REQ-034 rst asserted after the 4th beat -> count=0, out_mat all zero, out_valid=0; the next 6 beats form a fresh, correct matrix.
